// File: rtl/text_console_if.sv
// Character stream input and frame buffer write port of the text console.
// The slave modport is the console; the master modport is the host side, which also watches the write port.
interface text_console_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [5:0] x;
    logic [5:0] y;
    logic [5:0] char;
    logic       we;

    modport slave (
        input  in_valid, in_data,
        output in_ready, x, y, char, we
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, x, y, char, we
    );
endinterface

// File: rtl/text_console.sv
// Cursor-tracking text console that owns the frame buffer write port and expands clear-screen into a sweep.
// Optional macro TEXT_CONSOLE_CLEAR_ON_RESET_EN: sweep the whole buffer straight out of reset.
module text_console #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic              clk,
    input  logic              reset,
    text_console_if.slave     bus,
    output logic [5:0]        cur_x,
    output logic [5:0]        cur_y,
    output logic              busy
);
    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    localparam logic [5:0] LAST_X = 6'(COLS - 1);
    localparam logic [5:0] LAST_Y = 6'(ROWS - 1);

`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_IDLE;
`endif

    state_t     state, state_next;
    logic [5:0] sw_x, sw_y, sw_x_next, sw_y_next;
    logic [5:0] cur_x_next, cur_y_next;
    logic [5:0] x_next, y_next, char_next;
    logic       we_next, in_ready_next, busy_next;
    logic [5:0] row_inc;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next = state;
        sw_x_next  = sw_x;
        sw_y_next  = sw_y;
        cur_x_next = cur_x;
        cur_y_next = cur_y;
        x_next     = bus.x;
        y_next     = bus.y;
        char_next  = bus.char;
        we_next    = 1'b0;
        row_inc    = (cur_y == LAST_Y) ? 6'd0 : cur_y + 6'd1;

        case (state)
            S_IDLE: begin
                if (bus.in_valid && bus.in_ready) begin
                    if (!bus.in_data[7]) begin
                        x_next    = cur_x;
                        y_next    = cur_y;
                        char_next = bus.in_data[5:0];
                        we_next   = 1'b1;
                        if (cur_x == LAST_X) begin
                            cur_x_next = 6'd0;
                            cur_y_next = row_inc;
                        end else begin
                            cur_x_next = cur_x + 6'd1;
                        end
                    end else begin
                        case (bus.in_data)
                            8'h80: begin
                                cur_x_next = 6'd0;
                                cur_y_next = row_inc;
                            end
                            8'h81: begin
                                state_next = S_CLEAR;
                                sw_x_next  = 6'd0;
                                sw_y_next  = 6'd0;
                            end
                            8'h82: begin
                                cur_x_next = 6'd0;
                                cur_y_next = 6'd0;
                            end
                            8'h83: begin
                                // Retreat one cell, wrapping (0,0) to the bottom-right corner, and blank it.
                                if (cur_x != 6'd0) begin
                                    cur_x_next = cur_x - 6'd1;
                                end else begin
                                    cur_x_next = LAST_X;
                                    cur_y_next = (cur_y == 6'd0) ? LAST_Y : cur_y - 6'd1;
                                end
                                x_next    = cur_x_next;
                                y_next    = cur_y_next;
                                char_next = 6'd0;
                                we_next   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_CLEAR: begin
                x_next    = sw_x;
                y_next    = sw_y;
                char_next = 6'd0;
                we_next   = 1'b1;
                if (sw_x == LAST_X) begin
                    sw_x_next = 6'd0;
                    if (sw_y == LAST_Y) begin
                        sw_y_next  = 6'd0;
                        state_next = S_IDLE;
                        cur_x_next = 6'd0;
                        cur_y_next = 6'd0;
                    end else begin
                        sw_y_next = sw_y + 6'd1;
                    end
                end else begin
                    sw_x_next = sw_x + 6'd1;
                end
            end
        endcase

        in_ready_next = (state_next == S_IDLE);
        busy_next     = (state_next == S_CLEAR);
    end

    // Handshake flags are registered from the next state, so they never depend combinationally on in_*.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RESET_STATE;
            sw_x         <= 6'd0;
            sw_y         <= 6'd0;
            cur_x        <= 6'd0;
            cur_y        <= 6'd0;
            bus.x        <= 6'd0;
            bus.y        <= 6'd0;
            bus.char     <= 6'd0;
            bus.we       <= 1'b0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            sw_x         <= sw_x_next;
            sw_y         <= sw_y_next;
            cur_x        <= cur_x_next;
            cur_y        <= cur_y_next;
            bus.x        <= x_next;
            bus.y        <= y_next;
            bus.char     <= char_next;
            bus.we       <= we_next;
            bus.in_ready <= in_ready_next;
            busy         <= busy_next;
        end
    end
endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: glyph writes, cursor wrap, control codes, clear sweep and reset abort.
module tb_text_console;
    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] cur_x, cur_y;
    logic       busy;
    int         n_assert = 0;
    int         n_fail   = 0;

    text_console_if bus ();

    text_console dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .cur_x (cur_x),
        .cur_y (cur_y),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input int ex, input int ey, input int ech);
        check({tag, ".we"},   32'(bus.we),   1);
        check({tag, ".x"},    32'(bus.x),    ex);
        check({tag, ".y"},    32'(bus.y),    ey);
        check({tag, ".char"}, 32'(bus.char), ech);
    endtask

    task automatic check_cur(input string tag, input int ex, input int ey);
        check({tag, ".cur_x"}, 32'(cur_x), ex);
        check({tag, ".cur_y"}, 32'(cur_y), ey);
    endtask

    initial begin
        int we_count;
        bit order_ok;
        bit ready_ok;

        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        step();
        step();
        check("rst.we",       32'(bus.we),       0);
        check("rst.x",        32'(bus.x),        0);
        check("rst.y",        32'(bus.y),        0);
        check("rst.char",     32'(bus.char),     0);
        check("rst.in_ready", 32'(bus.in_ready), 0);
        check("rst.busy",     32'(busy),         0);
        check_cur("rst", 0, 0);

        reset = 1'b0;
        step();
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
        check("por.in_ready", 32'(bus.in_ready), 0);
        check("por.busy",     32'(busy),         1);
        check_wr("por.first", 0, 0, 0);
        repeat (1199) step();
        check("por.done.in_ready", 32'(bus.in_ready), 1);
        check("por.done.busy",     32'(busy),         0);
        check_wr("por.last", 39, 29, 0);
`else
        check("rel.in_ready", 32'(bus.in_ready), 1);
        check("rel.busy",     32'(busy),         0);
        check("rel.we",       32'(bus.we),       0);
`endif

        // Three glyphs back to back.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h01;
        step();
        check_wr("g1", 0, 0, 1);
        bus.in_data = 8'h02;
        step();
        check_wr("g2", 1, 0, 2);
        bus.in_data = 8'h03;
        step();
        check_wr("g3", 2, 0, 3);
        bus.in_valid = 1'b0;
        step();
        check("g_end.we", 32'(bus.we), 0);
        check("g_end.x_hold", 32'(bus.x), 2);
        check("g_end.char_hold", 32'(bus.char), 3);
        check_cur("g_end", 3, 0);

        // Home, then fill row 0 and wrap into row 1.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h82;
        step();
        check("home.we", 32'(bus.we), 0);
        check_cur("home", 0, 0);
        bus.in_data = 8'h05;
        we_count = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.we) we_count++;
        end
        check("row.we_count", 32'(we_count), 40);
        check_wr("row.last", 39, 0, 5);
        check_cur("row.last", 0, 1);
        bus.in_data = 8'h06;
        step();
        check_wr("row.wrap", 0, 1, 6);
        check_cur("row.wrap", 1, 1);

        // Walk to (7,29): 28 newlines then 7 glyphs.
        bus.in_data = 8'h80;
        repeat (28) step();
        check("nl.we", 32'(bus.we), 0);
        check_cur("nl", 0, 29);
        bus.in_data = 8'h07;
        repeat (7) step();
        check_wr("walk", 6, 29, 7);
        check_cur("walk", 7, 29);
        bus.in_data = 8'h80;
        step();
        check("nl_wrap.we", 32'(bus.we), 0);
        check_cur("nl_wrap", 0, 0);
        bus.in_data = 8'h83;
        step();
        check_wr("bs_wrap", 39, 29, 0);
        check_cur("bs_wrap", 39, 29);

        // Reserved control bytes are swallowed.
        bus.in_data = 8'h84;
        step();
        check("c84.we", 32'(bus.we), 0);
        check("c84.in_ready", 32'(bus.in_ready), 1);
        check_cur("c84", 39, 29);
        bus.in_data = 8'hFF;
        step();
        check("cff.we", 32'(bus.we), 0);
        check("cff.in_ready", 32'(bus.in_ready), 1);
        check_cur("cff", 39, 29);

        // Clear with a glyph waiting behind it.
        bus.in_data = 8'h81;
        step();
        check("clr.e0.in_ready", 32'(bus.in_ready), 0);
        check("clr.e0.busy",     32'(busy),         1);
        check("clr.e0.we",       32'(bus.we),       0);
        bus.in_data = 8'h11;
        we_count = 0;
        order_ok = 1'b1;
        ready_ok = 1'b1;
        for (int c = 1; c <= 1200; c++) begin
            step();
            if (bus.we) we_count++;
            if (!(bus.we === 1'b1 && int'(bus.x) == (c - 1) % 40 &&
                  int'(bus.y) == (c - 1) / 40 && bus.char === 6'd0))
                order_ok = 1'b0;
            if (c < 1200 && (bus.in_ready !== 1'b0 || busy !== 1'b1))
                ready_ok = 1'b0;
        end
        check("clr.we_count", 32'(we_count), 1200);
        check("clr.order",    32'(order_ok), 1);
        check("clr.ready_low", 32'(ready_ok), 1);
        check("clr.done.in_ready", 32'(bus.in_ready), 1);
        check("clr.done.busy",     32'(busy),         0);
        check_cur("clr.done", 0, 0);
        step();
        check_wr("clr.next", 0, 0, 17);
        check_cur("clr.next", 1, 0);

        // Abort a sweep with reset at sweep cycle 500.
        bus.in_data = 8'h81;
        step();
        bus.in_valid = 1'b0;
        repeat (500) step();
        check_wr("abort.pre", 19, 12, 0);
        reset = 1'b1;
        step();
        check("abort.we",       32'(bus.we),       0);
        check("abort.x",        32'(bus.x),        0);
        check("abort.in_ready", 32'(bus.in_ready), 0);
        check("abort.busy",     32'(busy),         0);
        check_cur("abort", 0, 0);
        reset = 1'b0;
        step();
`ifdef TEXT_CONSOLE_CLEAR_ON_RESET_EN
        ready_ok = 1'b1;
        for (int c = 1; c < 1200; c++) begin
            if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
            step();
        end
        check("abort.por_ready_low", 32'(ready_ok), 1);
        check("abort.por_ready", 32'(bus.in_ready), 1);
`else
        check("abort.rel.in_ready", 32'(bus.in_ready), 1);
        check("abort.rel.we",       32'(bus.we),       0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
